// File: rtl/vector_lsu_if.sv
// Command, status and data-memory port bundle for vector_lsu.
// master: command issuer plus the memory read-data return; slave: the sequencer.
// The vlen field is sized to hold 0..LANES inclusive.
interface vector_lsu_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 24,
  parameter int LANES      = 4
);
  localparam int VLEN_W = $clog2(LANES + 1);

  logic                        start;
  logic                        is_store;
  logic [ADDR_WIDTH-1:0]       base;
  logic [ADDR_WIDTH-1:0]       stride;
  logic [VLEN_W-1:0]           vlen;
  logic [LANES*DATA_WIDTH-1:0] store_data;
  logic                        busy;
  logic                        done;
  logic [LANES*DATA_WIDTH-1:0] load_data;
  logic                        err;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_wd;
  logic [DATA_WIDTH-1:0]       mem_rd;

  modport master (
    output start, is_store, base, stride, vlen, store_data, mem_rd,
    input  busy, done, load_data, err, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  start, is_store, base, stride, vlen, store_data, mem_rd,
    output busy, done, load_data, err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: expands one command into strided per-element memory accesses.
// Latency: store vlen+1 cycles, load vlen+2 cycles, vlen=0 one cycle; one element per cycle.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy.
// Optional bounds check enabled by defining VECTOR_LSU_BOUNDS_CHECK_EN.
module vector_lsu #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 24,
  parameter int LANES      = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  vector_lsu_if.slave  bus
);
  localparam int VW = $clog2(LANES + 1);

`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                      state;
  logic                        is_store_q;
  logic [ADDR_WIDTH-1:0]       stride_q;
  logic [VW-1:0]               vlen_q;
  logic [VW-1:0]               idx;
  logic [VW-1:0]               nidx;
  logic [LANES*DATA_WIDTH-1:0] store_q;
  logic [LANES*DATA_WIDTH-1:0] load_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_q;
  logic                        we_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wd_q;
  logic                        oob_q;      // element currently on the bus is out of range
  logic                        cap_vld;    // mem_rd this cycle belongs to a load element
  logic [VW-1:0]               cap_idx;
  logic                        cap_oob;
  logic [ADDR_WIDTH-1:0]       iss_addr;
  logic [DATA_WIDTH-1:0]       iss_lane;
  logic                        iss_store;
  logic                        iss_oob;

  // Next element to present: element 0 straight from the command inputs in IDLE,
  // otherwise the running address advanced by one stride.
  always_comb begin
    nidx = idx + VW'(1);
    if (state == IDLE) begin
      iss_addr  = bus.base;
      iss_lane  = bus.store_data[DATA_WIDTH-1:0];
      iss_store = bus.is_store;
    end else begin
      iss_addr  = addr_q + stride_q;
      iss_lane  = store_q[nidx*DATA_WIDTH +: DATA_WIDTH];
      iss_store = is_store_q;
    end
    iss_oob = CHECK_EN && (iss_addr >= ADDR_WIDTH'(MEM_DEPTH));
  end

  // Sequencer FSM with registered memory-side outputs and load-lane capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      stride_q   <= '0;
      vlen_q     <= '0;
      idx        <= '0;
      store_q    <= '0;
      load_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      oob_q      <= 1'b0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      cap_oob    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      cap_vld <= 1'b0;
      if (cap_vld) begin
        load_q[cap_idx*DATA_WIDTH +: DATA_WIDTH] <= cap_oob ? '0 : bus.mem_rd;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_store_q <= bus.is_store;
            stride_q   <= bus.stride;
            vlen_q     <= bus.vlen;
            store_q    <= bus.store_data;
            idx        <= '0;
            busy_q     <= 1'b1;
            if (bus.vlen == '0) begin
              err_q  <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              addr_q <= iss_addr;
              if (iss_store) wd_q <= iss_lane;
              we_q   <= iss_store && !iss_oob;
              oob_q  <= iss_oob;
              err_q  <= iss_oob;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cap_vld <= !is_store_q;
          cap_idx <= idx;
          cap_oob <= oob_q;
          if (idx == vlen_q - VW'(1)) begin
            we_q <= 1'b0;
            if (is_store_q) begin
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              state  <= DRAIN;
            end
          end else begin
            idx    <= nidx;
            addr_q <= iss_addr;
            if (iss_store) wd_q <= iss_lane;
            we_q   <= iss_store && !iss_oob;
            oob_q  <= iss_oob;
            if (iss_oob) err_q <= 1'b1;
          end
        end
        DRAIN: begin
          done_q <= 1'b1;
          state  <= FINISH;
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.load_data = load_q;
  assign bus.err       = err_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wd    = wd_q;
endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: directed vector table, abort-by-reset sequence, randomized commands.
// Expected traces come from a per-command model built on plain address arithmetic.
// A small synchronous memory answers reads one cycle after the address.
module tb_vector_lsu;
  localparam int DW    = 24;
  localparam int AW    = 24;
  localparam int LN    = 4;
  localparam int DEPTH = 256;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) bus ();

  vector_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] m_ld [LN];
  int n_cmp = 0;
  int n_bad = 0;

  // Memory behind the port: read data one cycle after the address, write on the edge.
  always @(posedge clk) begin
    bus.mem_rd <= dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : '0;
    if (bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wd;
  end

  task automatic chk(input string name, input logic [LN*DW-1:0] act, input logic [LN*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic bit model_oob(input logic [AW-1:0] a);
    return CHK_EN && (a >= AW'(DEPTH));
  endfunction

  // One command: model the expected trace, drive start, check every cycle through done.
  task automatic run_cmd(input bit st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                         input int vl, input logic [LN*DW-1:0] d, input bit poke, input int exp_dc);
    logic [AW-1:0]    a [LN];
    bit               oob [LN];
    bit               any_oob;
    logic [LN*DW-1:0] exp_ld;
    bit               exp_we;
    any_oob = 1'b0;
    for (int k = 0; k < vl; k++) begin
      a[k]   = b + AW'(k) * s;
      oob[k] = model_oob(a[k]);
      any_oob |= oob[k];
      if (st && !oob[k]) ref_mem[a[k]] = d[k*DW +: DW];
      if (!st) m_ld[k] = oob[k] ? '0 : ref_read(a[k]);
    end
    for (int i = 0; i < LN; i++) exp_ld[i*DW +: DW] = m_ld[i];

    @(negedge clk);
    chk("idle_busy", {95'b0, bus.busy}, 96'd0);
    chk("idle_we", {95'b0, bus.mem_we}, 96'd0);
    bus.is_store   = st;
    bus.base       = b;
    bus.stride     = s;
    bus.vlen       = 3'(vl);
    bus.store_data = d;
    bus.start      = 1'b1;
    for (int c = 1; c <= exp_dc; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
      if (poke && c == 2) begin
        bus.start = 1'b1; bus.is_store = ~st; bus.base = '0;
        bus.vlen = 3'(LN); bus.store_data = '1;
      end
      if (poke && c == 3) bus.start = 1'b0;
      @(negedge clk);
      exp_we = 1'b0;
      if (c <= vl) exp_we = st && !oob[c-1];
      chk("busy", {95'b0, bus.busy}, 96'd1);
      chk("done", {95'b0, bus.done}, {95'b0, c == exp_dc});
      chk("mem_we", {95'b0, bus.mem_we}, {95'b0, exp_we});
      if (c <= vl) begin
        chk("mem_addr", {72'b0, bus.mem_addr}, {72'b0, a[c-1]});
        if (st) chk("mem_wd", {72'b0, bus.mem_wd}, {72'b0, d[(c-1)*DW +: DW]});
      end
      if (c == exp_dc) begin
        chk("load_data", bus.load_data, exp_ld);
        chk("err", {95'b0, bus.err}, {95'b0, any_oob});
      end
    end
  endtask

  typedef struct {
    bit               st;
    logic [AW-1:0]    base;
    logic [AW-1:0]    stride;
    int               vl;
    logic [LN*DW-1:0] d;
    bit               poke;
    int               dc;
    logic [LN*DW-1:0] ld;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [LN*DW-1:0] d0;
    bit st;
    logic [AW-1:0] b, s;
    int vl, dc;
    bit pk;

    tbl[0] = '{1'b1, 24'd24, 24'd1, 4, 96'h444444_333333_222222_111111, 1'b0, 5, '0};
    tbl[1] = '{1'b0, 24'd24, 24'd1, 4, '0, 1'b0, 6, 96'h444444_333333_222222_111111};
    tbl[2] = '{1'b1, 24'd5, 24'd1, 0, 96'h1, 1'b0, 1, '0};
    tbl[3] = '{1'b1, 24'hFFFFFE, 24'd2, 3, 96'hDDDDDD_CCCCCC_BBBBBB_AAAAAA, 1'b0, 4, '0};
    tbl[4] = '{1'b0, 24'hFFFFFE, 24'd2, 3, '0, 1'b0, 5, 96'h444444_CCCCCC_BBBBBB_AAAAAA};
    tbl[5] = '{1'b0, 24'd25, 24'd1, 2, '0, 1'b1, 4, 96'h444444_CCCCCC_333333_222222};
    tbl[6] = '{1'b1, 24'd254, 24'd1, 4, 96'h5A5A04_5A5A03_5A5A02_5A5A01, 1'b0, 5, '0};
    tbl[7] = '{1'b0, 24'd27, 24'd1, 1, '0, 1'b0, 3, 96'h444444_CCCCCC_333333_444444};
    tbl[8] = '{1'b0, 24'd254, 24'd1, 4, '0, 1'b0, 6, 96'h5A5A04_5A5A03_5A5A02_5A5A01};
    tbl[9] = '{1'b1, 24'd40, 24'd3, 3, 96'h0_777777_666666_555555, 1'b1, 4, '0};

    for (int i = 0; i < LN; i++) m_ld[i] = '0;
    bus.start = 1'b1; bus.is_store = 1'b1; bus.base = '0; bus.stride = 24'd1;
    bus.vlen = 3'd4; bus.store_data = '1;

    // Reset held for three cycles with start asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {95'b0, bus.busy}, 96'd0);
    chk("rst_done", {95'b0, bus.done}, 96'd0);
    chk("rst_load", bus.load_data, 96'd0);
    chk("rst_err", {95'b0, bus.err}, 96'd0);
    chk("rst_we", {95'b0, bus.mem_we}, 96'd0);
    chk("rst_addr", {72'b0, bus.mem_addr}, 96'd0);
    chk("rst_wd", {72'b0, bus.mem_wd}, 96'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_we", {95'b0, bus.mem_we}, 96'd0);
      chk("post_rst_busy", {95'b0, bus.busy}, 96'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].st, tbl[i].base, tbl[i].stride, tbl[i].vl, tbl[i].d, tbl[i].poke, tbl[i].dc);
`ifndef VECTOR_LSU_BOUNDS_CHECK_EN
      if (!tbl[i].st) chk("tbl_load", bus.load_data, tbl[i].ld);
`endif
    end

    // Reset asserted in cycle 2 of a store: mem_we must drop before any clock edge.
    d0 = 96'h0D0D04_0D0D03_0D0D02_0D0D01;
    @(negedge clk);
    bus.is_store = 1'b1; bus.base = 24'd100; bus.stride = 24'd1;
    bus.vlen = 3'd4; bus.store_data = d0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_before", {95'b0, bus.mem_we}, 96'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_async", {95'b0, bus.mem_we}, 96'd0);
    chk("abort_busy", {95'b0, bus.busy}, 96'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ref_mem[24'd100] = d0[DW-1:0];
    for (int i = 0; i < LN; i++) m_ld[i] = '0;
    run_cmd(1'b0, 24'd100, 24'd1, 4, '0, 1'b0, 6);

    // Randomized commands, back to back.
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      b  = AW'($urandom_range(0, 300));
      s  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
      vl = $urandom_range(0, LN);
      d0 = {$urandom, $urandom, $urandom};
      dc = (vl == 0) ? 1 : (st ? vl + 1 : vl + 2);
      pk = (dc >= 3) && ($urandom_range(0, 3) == 0);
      run_cmd(st, b, s, vl, d0, pk, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store sequencer sitting directly upstream of the data memory (`topMemory`). It accepts one vector memory command and expands it into per-element memory accesses: one element per cycle, with a strided address per element. Store data comes from a lane-packed vector operand. Load data returns over the memory read port and is collected into a lane-packed result. It drives the memory's `we`/`a2`/`wd` inputs and consumes its `rd2` output.

## Interface
- `DATA_WIDTH`, 24, element width in bits (matches memory word).
- `ADDR_WIDTH`, 24, memory address width.
- `LANES`, 4, maximum vector length.
- `MEM_DEPTH`, 256, number of valid memory words; used only when bounds checking is compiled in.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load; latched with `start`.
- `base`  in  ADDR_WIDTH  address of element 0; latched with `start`.
- `stride`  in  ADDR_WIDTH  address increment per element (unsigned, modular); latched.
- `vlen`  in  $clog2(LANES+1)  element count, 0..LANES; latched.
- `store_data`  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; latched with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  LANES*DATA_WIDTH  collected load lanes; same packing as `store_data`.
- `err`  out  1  bounds violation flag (see Configuration).
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  ADDR_WIDTH  to memory `a2`.
- `mem_wd`  out  DATA_WIDTH  to memory `wd`.
- `mem_rd`  in  DATA_WIDTH  from memory `rd2`; valid one cycle after the address is presented.

## Operation
- Reset values: `busy`=0, `done`=0, `load_data`=0, `err`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0. The FSM goes to IDLE.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE, on `start`=1:
  - Latch the command and set element index i=0.
  - If `vlen`=0, go to FINISH; otherwise go to ISSUE.
  - `start` in any other state is ignored (not queued).
- ISSUE:
  - Present element i: `mem_addr` = base + i*stride, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - Store: `mem_we`=1 and `mem_wd` = lane i.
  - Load: `mem_we`=0.
  - Increment i each cycle. After element vlen-1, a store goes to FINISH and a load goes to DRAIN.
- Load capture: `mem_rd` sampled in the cycle after element i's address is written into `load_data` lane i. DRAIN covers the capture of the last element, then goes to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `mem_we` is 0 in every state other than ISSUE-with-store.
- `mem_addr`/`mem_wd` hold their last values when not issuing.
- `load_data` lanes ≥ vlen keep their previous contents. A store never modifies `load_data`. `load_data` is stable from `done` until the next load's first capture.
- Reset asserted mid-command: abort immediately (asynchronous). `mem_we` drops to 0 without waiting for a clock edge, and the partial command is discarded.

## Timing
- `start` sampled at edge 0. Element k is presented in cycle k+1, for k = 0..vlen-1.
- Store: `done` in cycle vlen+1. Latency = vlen+1 cycles.
- Load: last capture at the end of cycle vlen+1, `done` in cycle vlen+2.
- `vlen`=0: `done` in cycle 1, with no memory access.
- Back-to-back: a new `start` is accepted in the cycle after `done`. The minimum gap is 1 IDLE cycle.
- Throughput: 1 element per cycle, no bubbles within a command.

## Configuration
- `VECTOR_LSU_BOUNDS_CHECK_EN` defined:
  - Any element whose computed address is ≥ `MEM_DEPTH` is suppressed but still occupies its cycle: `mem_we` is forced to 0 for that element, and a load writes 0 into that lane.
  - `err` is set, stays sticky through `done`, and is cleared on the next accepted `start`.
- Macro undefined:
  - No check is done and every address is issued unmodified.
  - `err` is constant 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0, `busy`=0. Release → no memory activity until `start`.
- Store: base=24, stride=1, vlen=4, lanes 111111/222222/333333/444444 → `mem_we`=1 in cycles 1–4 with addresses 24..27 and the matching data, then `done` in cycle 5.
- Load of the same region: base=24, stride=1, vlen=4 → `load_data` = {444444,333333,222222,111111} (lane 3..0), `done` in cycle 6, `mem_we` stays 0.
- Edge cases: vlen=0 → `done` in cycle 1 with no `mem_we`. `start` while `busy` → ignored, and the current command completes unchanged.
- Wrap: base=FFFFFE, stride=2, vlen=3, store → addresses FFFFFE, 000000, 000002.
- Bounds (macro defined, MEM_DEPTH=256): store with base=254, stride=1, vlen=4 → writes at 254 and 255 only, `err`=1. The next command clears `err`. Assert `rst_n` in cycle 2 of a store → `mem_we` drops to 0 asynchronously.
